run_ctrl: RTL and testbench



---
 rtl/run_ctrl.sv | 139 +++++++++++++
 tb/tb_run_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run controller ahead of the clock divider: debounced start, held processor reset, run timing.
// Optional RUN_TIMEOUT_EN forces a run to stop after TIMEOUT fast cycles.
module run_ctrl #(
    parameter int unsigned DEB_CYCLES   = 100000,
    parameter int unsigned RST_CYCLES   = 2000,
    parameter int unsigned DRAIN_CYCLES = 1000,
    parameter logic [31:0] TIMEOUT      = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        proc_done,
    output logic        en,
    output logic        busy,
    output logic        proc_rst,
    output logic [31:0] run_cycles,
    output logic        result_valid,
    output logic        timeout
);

    // state | meaning
    // IDLE  | waiting for start, processor held in reset, divider stopped
    // PRST  | divider running with processor reset asserted
    // RUN   | processor running, run length being counted
    // DRAIN | done seen, divider kept running so the last divided edge completes
    // DONE  | result held, waiting for the next start
    typedef enum logic [2:0] {IDLE, PRST, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0] DEB_LAST   = 32'(DEB_CYCLES - 1);
    localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
`ifdef RUN_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 32'd1;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    state_t      state;
    logic        btn_s1, btn_s2, deb_level, start_pulse;
    logic [31:0] deb_cnt;
    logic        done_s1, done_s2, done_s3;
    logic        done_pulse;
    logic [31:0] tmr;
    logic [31:0] cycle_ctr;

    assign done_pulse = done_s2 & ~done_s3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_s1      <= 1'b0;
            btn_s2      <= 1'b0;
            deb_level   <= 1'b0;
            deb_cnt     <= '0;
            start_pulse <= 1'b0;
            done_s1     <= 1'b0;
            done_s2     <= 1'b0;
            done_s3     <= 1'b0;
        end else begin
            btn_s1      <= start_btn;
            btn_s2      <= btn_s1;
            done_s1     <= proc_done;
            done_s2     <= done_s1;
            done_s3     <= done_s2;
            start_pulse <= 1'b0;
            // any sample agreeing with the accepted level restarts the stability count
            if (btn_s2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level   <= btn_s2;
                deb_cnt     <= '0;
                start_pulse <= btn_s2;
            end else begin
                deb_cnt <= deb_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            tmr          <= '0;
            cycle_ctr    <= '0;
            run_cycles   <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            en           <= 1'b0;
            busy         <= 1'b0;
            proc_rst     <= 1'b1;
        end else begin
            en       <= (state == PRST) || (state == RUN) || (state == DRAIN);
            busy     <= (state == RUN);
            proc_rst <= (state == IDLE) || (state == PRST);
            case (state)
                IDLE, DONE: begin
                    if (start_pulse) begin
                        state <= PRST;
                        tmr   <= '0;
                    end
                end
                PRST: begin
                    if (tmr == RST_LAST) begin
                        state        <= RUN;
                        tmr          <= '0;
                        cycle_ctr    <= '0;
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                RUN: begin
                    if (cycle_ctr != 32'hFFFF_FFFF) cycle_ctr <= cycle_ctr + 32'd1;
                    if (done_pulse) begin
                        state        <= DRAIN;
                        tmr          <= '0;
                        run_cycles   <= cycle_ctr;
                        result_valid <= 1'b1;
                    end
`ifdef RUN_TIMEOUT_EN
                    else if (cycle_ctr == TIMEOUT_LAST) begin
                        state        <= DRAIN;
                        tmr          <= '0;
                        run_cycles   <= TIMEOUT;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (tmr == DRAIN_LAST) state <= DONE;
                    else tmr <= tmr + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a phase-level reference model checked every cycle.
module tb_run_ctrl;
    localparam int DEB  = 8;
    localparam int RSTC = 10;
    localparam int DRN  = 5;
    localparam logic [31:0] TOUT = 32'd50;

    localparam int PH_IDLE = 0, PH_PRST = 1, PH_RUN = 2, PH_DRAIN = 3, PH_DONE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_btn = 1'b0;
    logic        proc_done = 1'b0;
    logic        en, busy, proc_rst, result_valid, timeout;
    logic [31:0] run_cycles;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    run_ctrl #(
        .DEB_CYCLES(DEB),
        .RST_CYCLES(RSTC),
        .DRAIN_CYCLES(DRN),
        .TIMEOUT(TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_btn(start_btn),
        .proc_done(proc_done),
        .en(en),
        .busy(busy),
        .proc_rst(proc_rst),
        .run_cycles(run_cycles),
        .result_valid(result_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases with remaining-cycle countdowns, outputs lag the phase by one edge.
    int          ph = PH_IDLE;
    int          left = 0;
    int          m_run = 0;
    longint      elapsed = 0;
    bit          mb1 = 0, mb2 = 0, mlvl = 0, msp = 0;
    bit          md1 = 0, md2 = 0, md3 = 0;
    bit          e_en = 0, e_busy = 0, e_prst = 1, e_valid = 0, e_to = 0;
    logic [31:0] e_cycles = 0;

    always @(posedge clk) begin : model
        bit sp, dp;
        sp = msp;
        dp = md2 && !md3;
        if (!rst) begin
            ph = PH_IDLE; left = 0; m_run = 0; elapsed = 0;
            mb1 = 0; mb2 = 0; mlvl = 0; msp = 0; md1 = 0; md2 = 0; md3 = 0;
            e_en = 0; e_busy = 0; e_prst = 1; e_valid = 0; e_to = 0; e_cycles = 0;
        end else begin
            e_en   = (ph == PH_PRST) || (ph == PH_RUN) || (ph == PH_DRAIN);
            e_busy = (ph == PH_RUN);
            e_prst = (ph == PH_IDLE) || (ph == PH_PRST);
            msp = 0;
            if (mb2 != mlvl) begin
                m_run++;
                if (m_run == DEB) begin
                    mlvl  = mb2;
                    m_run = 0;
                    msp   = mlvl;
                end
            end else begin
                m_run = 0;
            end
            mb2 = mb1; mb1 = start_btn;
            md3 = md2; md2 = md1; md1 = proc_done;
            case (ph)
                PH_IDLE, PH_DONE: if (sp) begin ph = PH_PRST; left = RSTC; end
                PH_PRST: begin
                    left--;
                    if (left == 0) begin ph = PH_RUN; elapsed = 0; e_valid = 0; e_to = 0; end
                end
                PH_RUN: begin
                    elapsed++;
                    if (dp) begin
                        ph = PH_DRAIN; left = DRN; e_valid = 1;
                        e_cycles = (elapsed - 1 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(elapsed - 1);
                    end
`ifdef RUN_TIMEOUT_EN
                    else if (elapsed == longint'(TOUT)) begin
                        ph = PH_DRAIN; left = DRN; e_valid = 1; e_to = 1; e_cycles = TOUT;
                    end
`endif
                end
                PH_DRAIN: begin
                    left--;
                    if (left == 0) ph = PH_DONE;
                end
                default: ph = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("en", 32'(en), 32'(e_en));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("proc_rst", 32'(proc_rst), 32'(e_prst));
            chk("run_cycles", run_cycles, e_cycles);
            chk("result_valid", 32'(result_valid), 32'(e_valid));
            chk("timeout", 32'(timeout), 32'(e_to));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(3);
        chk_on = 1'b1;
        rst = 1'b1;
        step(1);
        chk("rst_en", 32'(en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_proc_rst", 32'(proc_rst), 1);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_result_valid", 32'(result_valid), 0);

        for (int i = 0; i < 10; i++) begin
            start_btn = ~start_btn;
            step(3);
        end
        chk("bounce_en", 32'(en), 0);
        chk("bounce_proc_rst", 32'(proc_rst), 1);

        // clean press: PRST entered 11 edges later, RUN 10 edges after that
        start_btn = 1'b1;
        step(11);
        chk("pre_prst_en", 32'(en), 0);
        step(1);
        start_btn = 1'b0;
        chk("prst_en", 32'(en), 1);
        chk("prst_proc_rst", 32'(proc_rst), 1);
        step(9);
        chk("prst_last_proc_rst", 32'(proc_rst), 1);
        chk("prst_last_busy", 32'(busy), 0);
        step(1);
        chk("run_proc_rst", 32'(proc_rst), 0);
        chk("run_busy", 32'(busy), 1);

        step(49);
        start_btn = 1'b1;
        step(12);
        start_btn = 1'b0;
        chk("run_press_busy", 32'(busy), 1);
        step(132);
        start_btn = 1'b1;
        step(6);
        proc_done = 1'b1;
        step(6);
        start_btn = 1'b0;
        chk("drain_busy", 32'(busy), 0);
        chk("drain_en", 32'(en), 1);
        chk("run1_cycles", run_cycles, 202);
        chk("model_run1_cycles", e_cycles, 202);
        chk("run1_valid", 32'(result_valid), 1);
        step(2);
        chk("drain_last_en", 32'(en), 1);
        step(1);
        chk("done_en", 32'(en), 0);
        step(21);
        chk("done_hold_en", 32'(en), 0);
        chk("done_hold_proc_rst", 32'(proc_rst), 0);
        chk("done_hold_cycles", run_cycles, 202);
        chk("done_hold_valid", 32'(result_valid), 1);

        // restart from DONE with proc_done still high: no edge, run must continue
        start_btn = 1'b1;
        step(12);
        start_btn = 1'b0;
        chk("prst2_en", 32'(en), 1);
        chk("prst2_proc_rst", 32'(proc_rst), 1);
        step(8);
        chk("prst2_valid", 32'(result_valid), 1);
        step(1);
        chk("run2_valid_cleared", 32'(result_valid), 0);
        chk("run2_cycles_held", run_cycles, 202);
        step(30);
        chk("run2_level_done_busy", 32'(busy), 1);
        rst = 1'b0;
        step(1);
        chk("midrun_rst_en", 32'(en), 0);
        chk("midrun_rst_busy", 32'(busy), 0);
        chk("midrun_rst_proc_rst", 32'(proc_rst), 1);
        chk("midrun_rst_cycles", run_cycles, 0);
        chk("midrun_rst_valid", 32'(result_valid), 0);
        chk("midrun_rst_timeout", 32'(timeout), 0);
        rst = 1'b1;
        proc_done = 1'b0;
        step(30);
        chk("post_rst_idle_en", 32'(en), 0);
        chk("post_rst_idle_proc_rst", 32'(proc_rst), 1);

`ifdef RUN_TIMEOUT_EN
        start_btn = 1'b1;
        step(12);
        start_btn = 1'b0;
        step(9);
        chk("to_run_timeout", 32'(timeout), 0);
        step(49);
        chk("to_busy", 32'(busy), 1);
        chk("to_pre_timeout", 32'(timeout), 0);
        step(1);
        chk("to_timeout", 32'(timeout), 1);
        chk("to_cycles", run_cycles, 50);
        chk("model_to_cycles", e_cycles, 50);
        chk("to_valid", 32'(result_valid), 1);
        step(20);
        start_btn = 1'b1;
        step(12);
        start_btn = 1'b0;
        step(9);
        chk("to2_timeout_cleared", 32'(timeout), 0);
        chk("to2_valid_cleared", 32'(result_valid), 0);
        step(47);
        proc_done = 1'b1;
        step(3);
        chk("to2_done_wins_timeout", 32'(timeout), 0);
        chk("to2_cycles", run_cycles, 49);
        chk("to2_valid", 32'(result_valid), 1);
        step(10);
        proc_done = 1'b0;
`endif

        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
